// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO with configurable width and power-of-two depth.
// Provides a live fill level, almost-full/almost-empty thresholds and sticky
// overflow/underflow flags.
// Define PARAM_SYNC_FIFO_FWFT_EN at compile time for first-word-fall-through reads.
// Without it, d_out is a registered output that updates on each accepted read.
module param_sync_fifo #(
    parameter int W     = 8,
    parameter int D     = 32,
    parameter int AF_TH = D - 4,
    parameter int AE_TH = 4
) (
    input  logic                 r_clk,
    input  logic                 w_rst,
    input  logic                 w_en,
    input  logic [W-1:0]         d_in,
    input  logic                 r_en,
    input  logic                 clr_err,
    output logic [W-1:0]         d_out,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [$clog2(D):0]   level,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int AW = $clog2(D);
    localparam logic [AW:0] D_LVL  = (AW+1)'(D);
    localparam logic [AW:0] AF_LVL = (AW+1)'(AF_TH);
    localparam logic [AW:0] AE_LVL = (AW+1)'(AE_TH);

    logic [W-1:0] mem [D];

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] level_q, level_d;
    logic        full_q, full_d;
    logic        empty_q, empty_d;
    logic        afull_q, afull_d;
    logic        aempty_q, aempty_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;
    logic        wr_acc, rd_acc;

    // Accept decisions use the registered flags, and all flags derive from next-state level.
    always_comb begin
        wr_acc   = w_en && !full_q;
        rd_acc   = r_en && !empty_q;
        wr_ptr_d = wr_ptr_q + (AW+1)'(wr_acc);
        rd_ptr_d = rd_ptr_q + (AW+1)'(rd_acc);
        level_d  = level_q + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
        full_d   = (level_d == D_LVL);
        empty_d  = (level_d == '0);
        afull_d  = (level_d >= AF_LVL);
        aempty_d = (level_d <= AE_LVL);
        // A rejected request in the same cycle takes priority over clr_err.
        ovf_d    = (w_en && full_q)  ? 1'b1 : (clr_err ? 1'b0 : ovf_q);
        unf_d    = (r_en && empty_q) ? 1'b1 : (clr_err ? 1'b0 : unf_q);
    end

    // Control state register; reset discards contents by zeroing pointers and level.
    always_ff @(posedge r_clk) begin
        if (w_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage array is never reset; only accepted writes update it.
    always_ff @(posedge r_clk) begin
        if (!w_rst && wr_acc) begin
            mem[wr_ptr_q[AW-1:0]] <= d_in;
        end
    end

`ifdef PARAM_SYNC_FIFO_FWFT_EN
    // Head word is presented combinationally from registered state; zero when empty.
    always_comb begin
        d_out = empty_q ? '0 : mem[rd_ptr_q[AW-1:0]];
    end
`else
    logic [W-1:0] dout_q, dout_d;

    // Registered read data holds until the next accepted read.
    always_comb begin
        dout_d = rd_acc ? mem[rd_ptr_q[AW-1:0]] : dout_q;
    end

    // Read data register, cleared by reset.
    always_ff @(posedge r_clk) begin
        if (w_rst) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign d_out = dout_q;
`endif

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign level        = level_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo (W=8, D=32, AF_TH=28, AE_TH=4).
// The driver keeps a queue-based model and pushes expected read data into a scoreboard.
// The monitor pops from the scoreboard whenever the DUT accepts a read.
module tb_param_sync_fifo;
    localparam int W = 8, D = 32, AF_TH = 28, AE_TH = 4, AW = 5;

    logic          r_clk = 1'b0;
    logic          w_rst = 1'b1;
    logic          w_en = 1'b0, r_en = 1'b0, clr_err = 1'b0;
    logic [W-1:0]  d_in = '0;
    logic [W-1:0]  d_out;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;
    logic [AW:0]   level;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] mq[$];
    logic [W-1:0] exp_q[$];
    bit           m_ovf = 1'b0, m_unf = 1'b0;

    param_sync_fifo #(.W(W), .D(D), .AF_TH(AF_TH), .AE_TH(AE_TH)) dut (
        .r_clk(r_clk), .w_rst(w_rst), .w_en(w_en), .d_in(d_in), .r_en(r_en),
        .clr_err(clr_err), .d_out(d_out), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 r_clk = ~r_clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_flags();
        int n;
        n = mq.size();
        check("level", 32'(level), n);
        check("full", 32'(full), 32'(n == D));
        check("empty", 32'(empty), 32'(n == 0));
        check("almost_full", 32'(almost_full), 32'(n >= AF_TH));
        check("almost_empty", 32'(almost_empty), 32'(n <= AE_TH));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_unf));
    endtask

    // One clock cycle of stimulus; model updated from the FIFO rules, then flags checked.
    task automatic cyc(input bit we, input logic [W-1:0] d, input bit re, input bit clr);
        bit was_full, was_empty;
        w_en = we; d_in = d; r_en = re; clr_err = clr;
        was_full  = (mq.size() == D);
        was_empty = (mq.size() == 0);
        if (re && !was_empty) exp_q.push_back(mq.pop_front());
        if (we && !was_full)  mq.push_back(d);
        if (we && was_full) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
        if (re && was_empty) m_unf = 1'b1; else if (clr) m_unf = 1'b0;
        @(posedge r_clk); #1;
        check_flags();
    endtask

    task automatic do_reset(input bit we);
        w_rst = 1'b1; w_en = we; r_en = 1'b0; clr_err = 1'b0; d_in = 8'h77;
        @(posedge r_clk); #1;
        w_rst = 1'b0; w_en = 1'b0;
        mq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        check_flags();
        check("reset_d_out", 32'(d_out), 32'h0);
    endtask

    // Monitor: detects accepted reads from DUT signals and compares with the scoreboard.
    initial begin : monitor
        bit pend, rst_s;
        logic [W-1:0] last;
        last = '0;
        forever begin
            @(negedge r_clk);
            pend  = r_en && !empty && !w_rst;
            rst_s = w_rst;
`ifdef PARAM_SYNC_FIFO_FWFT_EN
            if (empty === 1'b1) begin
                check("fwft_empty_d_out", 32'(d_out), 32'h0);
            end else if (pend) begin
                if (exp_q.size() == 0) check("unexpected_read", 32'h1, 32'h0);
                else check("d_out", 32'(d_out), 32'(exp_q.pop_front()));
            end
`else
            @(posedge r_clk); #1;
            if (rst_s) begin
                last = '0;
            end else if (pend) begin
                if (exp_q.size() == 0) check("unexpected_read", 32'h1, 32'h0);
                else last = exp_q.pop_front();
            end
            check("d_out", 32'(d_out), 32'(last));
`endif
        end
    end

    initial begin : driver
        repeat (2) @(posedge r_clk);
        #1;
        do_reset(1'b0);

        // Fill to full, then one write too many.
        for (int i = 0; i < 32; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        cyc(1'b1, 8'hAA, 1'b0, 1'b0);

        // Drain fully, then one read too many.
        for (int i = 0; i < 32; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
`ifndef PARAM_SYNC_FIFO_FWFT_EN
        check("underflow_hold", 32'(d_out), 32'h1F);
`endif
        cyc(1'b0, '0, 1'b0, 1'b1);

        // Pointer wrap: write 20, read 20, write 20.
        for (int i = 0; i < 20; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);

        // Down to level 10, then sustained simultaneous traffic.
        for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 50; i++) cyc(1'b1, 8'($urandom), 1'b1, 1'b0);

        // Simultaneous request while full, then while empty, then clear.
        for (int i = 0; i < 22; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
        cyc(1'b1, 8'hEE, 1'b1, 1'b0);
        for (int i = 0; i < 31; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b1, 8'h3C, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b0);

        // Randomised traffic with occasional error clears.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 2) != 0), 8'($urandom),
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 300; i++) begin
            cyc(1'($urandom_range(0, 3) == 0), 8'($urandom),
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
        end

        // Reset at level 15 with a concurrent write request.
        do_reset(1'b0);
        for (int i = 0; i < 15; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
        do_reset(1'b1);

        // Single write into empty, then read it back.
        cyc(1'b1, 8'h5A, 1'b0, 1'b0);
`ifdef PARAM_SYNC_FIFO_FWFT_EN
        check("fwft_head", 32'(d_out), 32'h5A);
`endif
        cyc(1'b0, '0, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, '0, 1'b0, 1'b0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/param_sync_fifo.md
# param_sync_fifo

Parametrised single-clock FIFO. Generalises the team's 32 x 8 FIFO to arbitrary width and power-of-two depth. Adds a live fill level, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a compile-time first-word-fall-through (FWFT) read mode. It sits on the read-clock side of the datapath, where producer and consumer share r_clk.

## Interface
- W, 8, data width in bits (≥1).
- D, 32, depth in words; power of two, ≥4. AW = $clog2(D).
- AF_TH, D-4, almost_full asserts when level ≥ AF_TH (1..D).
- AE_TH, 4, almost_empty asserts when level ≤ AE_TH (0..D-1).

Ports (reset w_rst, synchronous, active-high; clock r_clk):
- r_clk  in  1  clock; all state updates on rising edge.
- w_rst  in  1  synchronous active-high reset; overrides all other inputs.
- w_en  in  1  write request.
- d_in  in  W  write data.
- r_en  in  1  read request.
- clr_err  in  1  synchronous clear of overflow/underflow.
- d_out  out  W  read data.
- full  out  1  level == D.
- empty  out  1  level == 0.
- almost_full  out  1  level ≥ AF_TH.
- almost_empty  out  1  level ≤ AE_TH.
- level  out  AW+1  current word count, 0..D.
- overflow  out  1  sticky: write requested while full.
- underflow  out  1  sticky: read requested while empty.

## Operation
- Storage: D x W array, not reset. wr_ptr and rd_ptr are AW+1 bits binary; the array is indexed by the low AW bits. The MSB disambiguates full from empty. Pointers wrap modulo 2·D.
- Write accepted iff w_en && !full (flag value before the edge): mem[wr_ptr] <= d_in, wr_ptr += 1.
- Read accepted iff r_en && !empty: rd_ptr += 1.
- level: +1 on write-only, -1 on read-only, unchanged on both or neither.
- Simultaneous request, 0 < level < D: both accepted, level unchanged.
- Simultaneous request, full: read accepted, write rejected, overflow set, level D-1.
- Simultaneous request, empty: write accepted, read rejected, underflow set, level 1.
- Rejected write: array and pointers unchanged. Rejected read: d_out unchanged in standard mode.
- All flags are registered and computed from next-state level, so they are exact in the cycle after each edge.
- overflow/underflow: set on rejected request, cleared by clr_err. Set wins over a same-cycle clr_err.
- Reset values: wr_ptr=rd_ptr=0, level=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, d_out=0.
- Reset mid-operation discards all contents; a same-cycle w_en/r_en is ignored.

## Timing
- Write at edge k: level, empty, full and almost_* reflect it after edge k.
- Standard mode read latency is 1. d_out <= mem[rd_ptr] on the edge that accepts the read and holds until the next accepted read.
- Write-to-read turnaround: a word written at edge k is readable by r_en in cycle k+1.
- Back-to-back reads and writes are sustained at one word per cycle each, indefinitely.

## Configuration
- Macro PARAM_SYNC_FIFO_FWFT_EN.
- Defined: d_out = empty ? 0 : mem[rd_ptr[AW-1:0]] (combinational from registered state). The head word is visible without r_en; an accepted r_en pops it, and the next word appears after the same edge. A write into an empty FIFO at edge k presents that word on d_out after edge k.
- Undefined: standard registered read as described in Timing.
- Flag, level and error behaviour is identical in both modes.

## Test plan
Configuration for all scenarios: W=8, D=32, AF_TH=28, AE_TH=4.
- Reset, then write 0x00..0x1F (32 writes) -> almost_full rises after the 28th write, full=1 and level=32 after the 32nd. A 33rd write of 0xAA -> overflow=1, level=32, contents unchanged.
- Read 32 words -> d_out sequence 0x00..0x1F, empty=1 after the last read, almost_empty from level 4. A further read -> underflow=1, d_out holds 0x1F.
- Write 20, read 20, write 20 (pointers wrap past index 31) -> read-back order exact, level=20, no error flags.
- At level 10, assert w_en and r_en for 50 cycles -> level stays 10, all flags stable, output data in FIFO order.
- Full with w_en=r_en=1 -> level 31, overflow=1. Empty with both asserted -> level 1, underflow=1. clr_err -> both flags 0 next cycle.
- Reset at level 15 with w_en=1 -> level 0, empty=1, d_out=0, errors 0. With PARAM_SYNC_FIFO_FWFT_EN: write 0x5A into empty -> d_out=0x5A after that edge with no r_en.
